// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared definitions for the memory-port arbiter: FSM state
//               encoding, requester/owner encoding and the default starvation
//               limit for the fetch requester.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Arbiter FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    // Transaction owner encoding; also the bit position in the one-hot grant
    localparam logic [1:0] OWN_IF = 2'd0;
    localparam logic [1:0] OWN_LD = 2'd1;
    localparam logic [1:0] OWN_ST = 2'd2;

    // Lost arbitrations tolerated before fetch is forced to win
    localparam int MEM_ARB_STARVE_LIMIT = 4;

    // Convert a one-hot grant vector into the owner encoding
    function automatic logic [1:0] grant_to_owner(input logic [2:0] grant);
        logic [1:0] owner;
        owner = OWN_IF;
        if (grant[OWN_ST]) begin
            owner = OWN_ST;
        end else if (grant[OWN_LD]) begin
            owner = OWN_LD;
        end
        return owner;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_prio_sel
// Description : Combinational fixed-priority selector (store > load > fetch)
//               with a starvation override that hands the grant to fetch.
// Ports       : if_valid/ld_valid/st_valid - requester valids
//               starve_force               - fetch has hit its starvation limit
//               grant[2:0]                 - one-hot grant, bit index = owner code
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_prio_sel
    import mem_port_arbiter_pkg::*;
(
    input  logic       if_valid,
    input  logic       ld_valid,
    input  logic       st_valid,
    input  logic       starve_force,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        if (starve_force && if_valid) begin
            grant[OWN_IF] = 1'b1;
        end else if (st_valid) begin
            grant[OWN_ST] = 1'b1;
        end else if (ld_valid) begin
            grant[OWN_LD] = 1'b1;
        end else if (if_valid) begin
            grant[OWN_IF] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one backend memory port between instruction fetch,
//               mem-stage load and mem-stage store. One transaction in flight;
//               completion pulse and read data are routed back to the owner.
//               Flush drops the response of an in-flight fetch.
// Ports       : clock, reset_n (async, active-low), flush
//               if_req_* / ld_req_* / st_req_*  - requester handshakes
//               *_resp_done, resp_rdata         - completion back to owners
//               mem_req_*                       - downstream request
//               mem_resp_valid/mem_resp_rdata   - downstream completion
//               perf_* (MEM_ARB_PERF_CNT_EN only) - grant and busy counters
// Config      : define MEM_ARB_PERF_CNT_EN to add the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int IDX_W        = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = MEM_ARB_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [IDX_W-1:0]  if_req_index,
    output logic              if_resp_done,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [IDX_W-1:0]  ld_req_index,
    output logic              ld_resp_done,
    input  logic              st_req_valid,
    output logic              st_req_ready,
    input  logic [IDX_W-1:0]  st_req_index,
    input  logic [DATA_W-1:0] st_req_wdata,
    input  logic [DATA_W-1:0] st_req_wmask,
    output logic              st_resp_done,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [IDX_W-1:0]  mem_req_index,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [DATA_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_ld_grants,
    output logic [31:0]       perf_st_grants,
    output logic [31:0]       perf_busy_cycles
`endif
);

    // Wide enough to hold 0..STARVE_LIMIT
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] wmask_q, wmask_d;
    logic              write_q, write_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic [2:0]        grant;
    logic              starve_force;
    logic              accept;
    logic              resp_fire;
    logic              owner_is_if;

    assign starve_force = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    mem_arb_prio_sel u_prio_sel (
        .if_valid     (if_req_valid),
        .ld_valid     (ld_req_valid),
        .st_valid     (st_req_valid),
        .starve_force (starve_force),
        .grant        (grant)
    );

    // Readies are qualified with reset_n so nothing appears accepted while
    // the block is held in reset.
    assign accept       = reset_n && (state_q == ARB_IDLE) && (|grant);
    assign if_req_ready = accept && grant[OWN_IF];
    assign ld_req_ready = accept && grant[OWN_LD];
    assign st_req_ready = accept && grant[OWN_ST];

    assign owner_is_if  = (owner_q == OWN_IF);
    assign resp_fire    = (state_q == ARB_WAIT) && mem_resp_valid;

    // A flush landing in the completion cycle suppresses the pulse directly,
    // since the drop flag would only be visible a cycle too late.
    assign if_resp_done = resp_fire && owner_is_if && !drop_q && !flush;
    assign ld_resp_done = resp_fire && (owner_q == OWN_LD);
    assign st_resp_done = resp_fire && (owner_q == OWN_ST);
    assign resp_rdata   = (resp_fire && (owner_q != OWN_ST)) ? mem_resp_rdata : '0;

    assign mem_req_valid = (state_q == ARB_ISSUE);
    assign mem_req_write = write_q;
    assign mem_req_index = index_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        index_d      = index_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        write_d      = write_q;
        drop_d       = drop_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    owner_d = grant_to_owner(grant);
                    drop_d  = 1'b0;
                    state_d = ARB_ISSUE;
                    if (grant[OWN_ST]) begin
                        index_d = st_req_index;
                        wdata_d = st_req_wdata;
                        wmask_d = st_req_wmask;
                        write_d = 1'b1;
                    end else begin
                        index_d = grant[OWN_LD] ? ld_req_index : if_req_index;
                        wdata_d = '0;
                        wmask_d = '0;
                        write_d = 1'b0;
                    end
                    // Count only arbitrations fetch actually competed in and lost
                    if (grant[OWN_IF]) begin
                        starve_cnt_d = '0;
                    end else if (if_req_valid && !starve_force) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end
            end
            ARB_ISSUE: begin
                if (flush && owner_is_if) begin
                    drop_d = 1'b1;
                end
                if (mem_req_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (flush && owner_is_if) begin
                    drop_d = 1'b1;
                end
                if (mem_resp_valid) begin
                    drop_d  = 1'b0;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_IF;
            index_q      <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            write_q      <= 1'b0;
            drop_q       <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            index_q      <= index_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            write_q      <= write_d;
            drop_q       <= drop_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_grants_q, perf_if_grants_d;
    logic [31:0] perf_ld_grants_q, perf_ld_grants_d;
    logic [31:0] perf_st_grants_q, perf_st_grants_d;
    logic [31:0] perf_busy_cycles_q, perf_busy_cycles_d;

    always_comb begin
        perf_if_grants_d   = perf_if_grants_q   + {31'd0, if_req_ready};
        perf_ld_grants_d   = perf_ld_grants_q   + {31'd0, ld_req_ready};
        perf_st_grants_d   = perf_st_grants_q   + {31'd0, st_req_ready};
        perf_busy_cycles_d = perf_busy_cycles_q + {31'd0, (state_q != ARB_IDLE)};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_if_grants_q   <= '0;
            perf_ld_grants_q   <= '0;
            perf_st_grants_q   <= '0;
            perf_busy_cycles_q <= '0;
        end else begin
            perf_if_grants_q   <= perf_if_grants_d;
            perf_ld_grants_q   <= perf_ld_grants_d;
            perf_st_grants_q   <= perf_st_grants_d;
            perf_busy_cycles_q <= perf_busy_cycles_d;
        end
    end

    assign perf_if_grants   = perf_if_grants_q;
    assign perf_ld_grants   = perf_ld_grants_q;
    assign perf_st_grants   = perf_st_grants_q;
    assign perf_busy_cycles = perf_busy_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//               followed by a randomized phase, all checked cycle by cycle
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        if_req_valid, if_req_ready, if_resp_done;
    logic [63:0] if_req_index;
    logic        ld_req_valid, ld_req_ready, ld_resp_done;
    logic [63:0] ld_req_index;
    logic        st_req_valid, st_req_ready, st_resp_done;
    logic [63:0] st_req_index, st_req_wdata, st_req_wmask;
    logic [63:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [63:0] mem_req_index, mem_req_wdata, mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_grants, perf_ld_grants, perf_st_grants, perf_busy_cycles;
`endif

    mem_port_arbiter dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .flush          (flush),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_req_index   (if_req_index),
        .if_resp_done   (if_resp_done),
        .ld_req_valid   (ld_req_valid),
        .ld_req_ready   (ld_req_ready),
        .ld_req_index   (ld_req_index),
        .ld_resp_done   (ld_resp_done),
        .st_req_valid   (st_req_valid),
        .st_req_ready   (st_req_ready),
        .st_req_index   (st_req_index),
        .st_req_wdata   (st_req_wdata),
        .st_req_wmask   (st_req_wmask),
        .st_resp_done   (st_resp_done),
        .resp_rdata     (resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_index  (mem_req_index),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_if_grants   (perf_if_grants),
        .perf_ld_grants   (perf_ld_grants),
        .perf_st_grants   (perf_st_grants),
        .perf_busy_cycles (perf_busy_cycles)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding transaction described by its owner
    // (0 fetch, 1 load, 2 store), payload, whether downstream took it, and
    // whether a flush has cancelled its response.
    bit          m_busy, m_sent, m_drop;
    int          m_owner;
    logic [63:0] m_idx, m_wd, m_wm;
    int          m_lost;
    int          m_grants[3];
    int          m_busy_cycles;
    int          last_grant;
    int          done_seen[3];
    logic [63:0] done_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_sent = 0; m_drop = 0; m_owner = 0;
        m_idx = '0; m_wd = '0; m_wm = '0; m_lost = 0;
        m_grants[0] = 0; m_grants[1] = 0; m_grants[2] = 0;
        m_busy_cycles = 0;
    endtask

    task automatic clr_seen();
        done_seen[0] = 0; done_seen[1] = 0; done_seen[2] = 0;
        done_rdata = 'x;
    endtask

    function automatic int pick();
        if (m_lost == LIMIT && if_req_valid) return 0;
        if (st_req_valid) return 2;
        if (ld_req_valid) return 1;
        if (if_req_valid) return 0;
        return -1;
    endfunction

    // One clock cycle: check outputs at the falling edge against the model,
    // advance the model, then return just after the next rising edge.
    task automatic step();
        int          win;
        logic [2:0]  exp_ready;
        logic [2:0]  exp_done;
        logic [63:0] exp_rdata;
        logic        exp_mvalid;
        @(negedge clock);
        last_grant = -1;
        exp_ready  = 3'b000;
        exp_done   = 3'b000;
        exp_rdata  = '0;
        exp_mvalid = 1'b0;
        win        = -1;
        if (!reset_n) begin
            model_clear();
            chk("rst_mem_write", {63'd0, mem_req_write}, 64'd0);
            chk("rst_mem_index", mem_req_index, 64'd0);
            chk("rst_mem_wdata", mem_req_wdata, 64'd0);
            chk("rst_mem_wmask", mem_req_wmask, 64'd0);
        end else begin
            if (!m_busy) begin
                win = pick();
                if (win >= 0) exp_ready[win] = 1'b1;
            end else if (!m_sent) begin
                exp_mvalid = 1'b1;
            end else if (mem_resp_valid) begin
                exp_done[m_owner] = !(m_owner == 0 && (m_drop || flush));
                exp_rdata = (m_owner == 2) ? 64'd0 : mem_resp_rdata;
            end
            if (exp_mvalid) begin
                chk("mem_write", {63'd0, mem_req_write}, {63'd0, (m_owner == 2)});
                chk("mem_index", mem_req_index, m_idx);
                chk("mem_wdata", mem_req_wdata, m_wd);
                chk("mem_wmask", mem_req_wmask, m_wm);
            end
        end
        chk("ready", {61'd0, st_req_ready, ld_req_ready, if_req_ready}, {61'd0, exp_ready});
        chk("done",  {61'd0, st_resp_done, ld_resp_done, if_resp_done}, {61'd0, exp_done});
        chk("rdata", resp_rdata, exp_rdata);
        chk("mem_valid", {63'd0, mem_req_valid}, {63'd0, exp_mvalid});

        if (if_resp_done) begin done_seen[0]++; done_rdata = resp_rdata; end
        if (ld_resp_done) begin done_seen[1]++; done_rdata = resp_rdata; end
        if (st_resp_done) begin done_seen[2]++; done_rdata = resp_rdata; end

        if (reset_n) begin
            if (m_busy) m_busy_cycles++;
            if (!m_busy) begin
                if (win >= 0) begin
                    m_grants[win]++;
                    last_grant = win;
                    m_busy  = 1; m_sent = 0; m_drop = 0; m_owner = win;
                    m_idx   = (win == 2) ? st_req_index : (win == 1) ? ld_req_index : if_req_index;
                    m_wd    = (win == 2) ? st_req_wdata : 64'd0;
                    m_wm    = (win == 2) ? st_req_wmask : 64'd0;
                    if (win == 0) m_lost = 0;
                    else if (if_req_valid && m_lost < LIMIT) m_lost++;
                end
            end else begin
                if (m_owner == 0 && flush) m_drop = 1;
                if (!m_sent) begin
                    if (mem_req_ready) m_sent = 1;
                end else if (mem_resp_valid) begin
                    m_busy = 0;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0;
        if_req_valid = 0; ld_req_valid = 0; st_req_valid = 0;
        mem_req_ready = 0; mem_resp_valid = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        step();
        step();
        reset_n = 1;
    endtask

    // Complete transaction with immediate downstream ready and response
    task automatic do_txn(input int who, input logic [63:0] idx, input logic [63:0] rd);
        if (who == 0) begin if_req_valid = 1; if_req_index = idx; end
        if (who == 1) begin ld_req_valid = 1; ld_req_index = idx; end
        if (who == 2) begin
            st_req_valid = 1; st_req_index = idx;
            st_req_wdata = ~idx; st_req_wmask = {32'd0, 32'hFFFF_FFFF};
        end
        mem_req_ready = 1;
        step();
        if_req_valid = 0; ld_req_valid = 0; st_req_valid = 0;
        step();
        mem_resp_valid = 1; mem_resp_rdata = rd;
        step();
        mem_resp_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int exp_ord[10];
        exp_ord = '{2, 2, 2, 2, 0, 2, 2, 2, 2, 0};

        reset_n = 0;
        idle_inputs();
        if_req_index = '0; ld_req_index = '0; st_req_index = '0;
        st_req_wdata = '0; st_req_wmask = '0; mem_resp_rdata = '0;
        model_clear();
        clr_seen();
        @(posedge clock);
        #1;
        // Reset with requests pending: no ready may appear
        if_req_valid = 1; ld_req_valid = 1; st_req_valid = 1;
        step();
        step();
        idle_inputs();
        reset_n = 1;
        step();

        // Single load
        clr_seen();
        ld_req_valid = 1; ld_req_index = 64'h40; mem_req_ready = 1;
        step();
        ld_req_valid = 0;
        step();
        mem_resp_valid = 1; mem_resp_rdata = 64'hDEADBEEF;
        step();
        mem_resp_valid = 0;
        step();
        chk("load_done_count", 64'(done_seen[1]), 64'd1);
        chk("load_rdata", done_rdata, 64'hDEADBEEF);

        // Store with three cycles of backpressure
        clr_seen();
        st_req_valid = 1; st_req_index = 64'h88;
        st_req_wdata = 64'hAB00; st_req_wmask = 64'hFF00; mem_req_ready = 0;
        step();
        st_req_valid = 0; st_req_wdata = 64'h1234; st_req_wmask = 64'h5678;
        repeat (3) step();
        mem_req_ready = 1;
        step();
        mem_resp_valid = 1; mem_resp_rdata = 64'hCAFE_F00D;
        step();
        mem_resp_valid = 0;
        step();
        chk("store_done_count", 64'(done_seen[2]), 64'd1);
        chk("store_rdata", done_rdata, 64'd0);

        // Contention: starvation guard forces every fifth grant to fetch
        do_reset();
        if_req_valid = 1; ld_req_valid = 1; st_req_valid = 1;
        if_req_index = 64'h10; ld_req_index = 64'h20; st_req_index = 64'h30;
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 64'h77;
        for (int i = 0; i < 31; i++) begin
            step();
            if (last_grant >= 0) q.push_back(last_grant);
        end
        idle_inputs();
        step();
        chk("contention_grants", 64'(q.size()), 64'd11);
        for (int i = 0; i < 10; i++) begin
            if (i < q.size()) chk($sformatf("grant_order_%0d", i), 64'(q[i]), 64'(exp_ord[i]));
        end

        // Flush of an in-flight fetch
        clr_seen();
        if_req_valid = 1; if_req_index = 64'h99; mem_req_ready = 1;
        step();
        if_req_valid = 0;
        step();
        flush = 1;
        step();
        flush = 0; mem_resp_valid = 1; mem_resp_rdata = 64'h5555;
        step();
        mem_resp_valid = 0;
        step();
        chk("flush_if_done_count", 64'(done_seen[0]), 64'd0);
        do_txn(1, 64'h44, 64'hABCD);
        chk("post_flush_load_done", 64'(done_seen[1]), 64'd1);
        chk("post_flush_load_rdata", done_rdata, 64'hABCD);

        // Reset in WAIT followed by a stray response
        clr_seen();
        ld_req_valid = 1; ld_req_index = 64'h60; mem_req_ready = 1;
        step();
        ld_req_valid = 0;
        step();
        reset_n = 0;
        step();
        reset_n = 1; mem_resp_valid = 1; mem_resp_rdata = 64'hBAD;
        step();
        mem_resp_valid = 0;
        step();
        chk("reset_stray_done", 64'(done_seen[0] + done_seen[1] + done_seen[2]), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if_req_valid   = ($urandom_range(0, 2) != 0);
            ld_req_valid   = ($urandom_range(0, 2) == 0);
            st_req_valid   = ($urandom_range(0, 2) == 0);
            if_req_index   = {$urandom, $urandom};
            ld_req_index   = {$urandom, $urandom};
            st_req_index   = {$urandom, $urandom};
            st_req_wdata   = {$urandom, $urandom};
            st_req_wmask   = {$urandom, $urandom};
            flush          = ($urandom_range(0, 7) == 0);
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            mem_resp_valid = ($urandom_range(0, 2) == 0);
            mem_resp_rdata = {$urandom, $urandom};
            step();
        end
        idle_inputs();

`ifdef MEM_ARB_PERF_CNT_EN
        do_reset();
        do_txn(1, 64'h100, 64'h1);
        do_txn(2, 64'h108, 64'h2);
        do_txn(1, 64'h110, 64'h3);
        do_txn(2, 64'h118, 64'h4);
        do_txn(1, 64'h120, 64'h5);
        step();
        chk("perf_ld_grants", 64'(perf_ld_grants), 64'd3);
        chk("perf_st_grants", 64'(perf_st_grants), 64'd2);
        chk("perf_if_grants", 64'(perf_if_grants), 64'd0);
        chk("perf_busy_cycles", 64'(perf_busy_cycles), 64'd10);
        chk("perf_busy_model", 64'(perf_busy_cycles), 64'(m_busy_cycles));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
